// File: rtl/xb_pkg.sv
// Shared definitions for the writeback arbiter: source indices, the buffered
// entry layout at the default widths, and the round-robin advance helper.
package xb_pkg;

  localparam int SRC_ALU = 0;
  localparam int SRC_MUL = 1;
  localparam int SRC_SHF = 2;
  localparam int NUM_SRC = 3;

  localparam int XB_DATA_WIDTH    = 16;
  localparam int XB_ADDRESS_WIDTH = 4;

  // One buffered result: destination register and the data to write there.
  typedef struct packed {
    logic [XB_ADDRESS_WIDTH-1:0] wadd;
    logic [XB_DATA_WIDTH-1:0]    dt;
  } xb_entry_t;

  // Source that follows src in ALU -> MUL -> SHF -> ALU order.
  function automatic logic [1:0] rr_next(input logic [1:0] src);
    return (src == 2'(NUM_SRC - 1)) ? 2'(SRC_ALU) : src + 2'd1;
  endfunction

endpackage

// File: rtl/xb_wb_fifo.sv
// Small synchronous FIFO buffering one execution source's results.
// full/empty come straight from the occupancy register, so the source-facing
// ready never depends on the source's own valid.
module xb_wb_fifo #(
  parameter int WIDTH = 20,
  parameter int DEPTH = 2
) (
  input  logic             clk_xb,
  input  logic             rst_xb,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  // A push into a full FIFO is refused even if the same edge pops it.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  // Pointers and occupancy; pointers wrap naturally since DEPTH is 2**PW.
  always_ff @(posedge clk_xb) begin
    if (rst_xb) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage array; contents are don't-care while the FIFO is empty.
  always_ff @(posedge clk_xb) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/xb_wb_arbiter.sv
// Writeback arbiter: three per-source FIFOs, round-robin grant, one registered
// register-file write per cycle and a per-register pending-write mask.
//
// Source handshake: a result transfers on a rising edge where vld && rdy.
// rdy is purely a function of the source FIFO's occupancy (count < depth),
// so a source may wait on rdy before raising vld and there is no
// combinational path from any vld to any rdy. A source holds its wadd/dt
// stable while vld is high and rdy is low.
module xb_wb_arbiter
  import xb_pkg::*;
#(
  parameter int DATA_WIDTH    = 16,
  parameter int ADDRESS_WIDTH = 4,
  parameter int FIFO_DEPTH    = 2
) (
  input  logic                        clk_xb,
  input  logic                        rst_xb,
  input  logic                        alu_xb_vld,
  input  logic                        mul_xb_vld,
  input  logic                        shf_xb_vld,
  output logic                        xb_alu_rdy,
  output logic                        xb_mul_rdy,
  output logic                        xb_shf_rdy,
  input  logic [ADDRESS_WIDTH-1:0]    alu_xb_wadd,
  input  logic [ADDRESS_WIDTH-1:0]    mul_xb_wadd,
  input  logic [ADDRESS_WIDTH-1:0]    shf_xb_wadd,
  input  logic [DATA_WIDTH-1:0]       alu_xb_dt,
  input  logic [DATA_WIDTH-1:0]       mul_xb_dt,
  input  logic [DATA_WIDTH-1:0]       shf_xb_dt,
  output logic                        xb_rf_w_En,
  output logic [ADDRESS_WIDTH-1:0]    xb_rf_wadd,
  output logic [DATA_WIDTH-1:0]       xb_rf_dt,
  output logic [2**ADDRESS_WIDTH-1:0] xb_ps_busy
);

  localparam int EW   = ADDRESS_WIDTH + DATA_WIDTH;
  localparam int NREG = 2**ADDRESS_WIDTH;

  logic [NUM_SRC-1:0] src_vld;
  logic [NUM_SRC-1:0] src_push;
  logic [NUM_SRC-1:0] src_pop;
  logic [NUM_SRC-1:0] src_full;
  logic [NUM_SRC-1:0] src_empty;
  logic [EW-1:0]      src_in   [NUM_SRC];
  logic [EW-1:0]      src_head [NUM_SRC];

  logic [1:0]         rr_ptr;
  logic               grant_vld;
  logic [1:0]         grant_src;
  logic [2:0]         cand;
  logic [EW-1:0]      grant_entry;

  logic [NREG-1:0]    busy_set;
  logic [NREG-1:0]    busy_clr;
  logic [NREG-1:0]    busy_next;

  assign src_vld          = {shf_xb_vld, mul_xb_vld, alu_xb_vld};
  assign src_in[SRC_ALU]  = {alu_xb_wadd, alu_xb_dt};
  assign src_in[SRC_MUL]  = {mul_xb_wadd, mul_xb_dt};
  assign src_in[SRC_SHF]  = {shf_xb_wadd, shf_xb_dt};

  assign xb_alu_rdy = ~src_full[SRC_ALU];
  assign xb_mul_rdy = ~src_full[SRC_MUL];
  assign xb_shf_rdy = ~src_full[SRC_SHF];
  assign src_push   = src_vld & ~src_full;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    xb_wb_fifo #(
      .WIDTH (EW),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk_xb (clk_xb),
      .rst_xb (rst_xb),
      .push   (src_push[g]),
      .pop    (src_pop[g]),
      .din    (src_in[g]),
      .full   (src_full[g]),
      .empty  (src_empty[g]),
      .head   (src_head[g])
    );
  end

  // Round-robin search over non-empty heads, starting at rr_ptr.
  always_comb begin
    grant_vld = 1'b0;
    grant_src = rr_ptr;
    cand      = '0;
    src_pop   = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      cand = {1'b0, rr_ptr} + 3'(k);
      if (cand >= 3'(NUM_SRC)) cand = cand - 3'(NUM_SRC);
      if (!grant_vld && !src_empty[cand[1:0]]) begin
        grant_vld = 1'b1;
        grant_src = cand[1:0];
      end
    end
    if (grant_vld) src_pop[grant_src] = 1'b1;
  end

  assign grant_entry = src_head[grant_src];

  // Pending mask: set on accept, clear the edge after the write is presented;
  // a same-edge set overrides the clear.
  always_comb begin
    busy_set = '0;
    busy_clr = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      if (src_push[s]) busy_set[src_in[s][EW-1:DATA_WIDTH]] = 1'b1;
    end
    if (xb_rf_w_En) busy_clr[xb_rf_wadd] = 1'b1;
    busy_next = (xb_ps_busy & ~busy_clr) | busy_set;
  end

  // Output write port, busy mask and round-robin pointer.
  always_ff @(posedge clk_xb) begin
    if (rst_xb) begin
      rr_ptr     <= 2'(SRC_ALU);
      xb_rf_w_En <= 1'b0;
      xb_rf_wadd <= '0;
      xb_rf_dt   <= '0;
      xb_ps_busy <= '0;
    end else begin
      xb_ps_busy <= busy_next;
      xb_rf_w_En <= grant_vld;
      if (grant_vld) begin
        xb_rf_wadd <= grant_entry[EW-1:DATA_WIDTH];
        xb_rf_dt   <= grant_entry[DATA_WIDTH-1:0];
        rr_ptr     <= rr_next(grant_src);
      end
    end
  end

endmodule

// File: tb/tb_xb_wb_arbiter.sv
// Bench for xb_wb_arbiter: directed vector table, hand sequences for
// back-pressure, fairness and reset, then randomized traffic against a
// queue-based reference model.
module tb_xb_wb_arbiter;
  import xb_pkg::*;

  localparam int DW    = 16;
  localparam int AW    = 4;
  localparam int DEPTH = 2;

  // ---------------- clock / reset ----------------
  logic clk_xb = 1'b0;
  logic rst_xb;
  always #5 clk_xb = ~clk_xb;

  logic [2:0]       vld;
  logic [AW-1:0]    wa  [3];
  logic [DW-1:0]    din [3];
  logic             xb_alu_rdy, xb_mul_rdy, xb_shf_rdy;
  logic             xb_rf_w_En;
  logic [AW-1:0]    xb_rf_wadd;
  logic [DW-1:0]    xb_rf_dt;
  logic [2**AW-1:0] xb_ps_busy;

  xb_wb_arbiter #(
    .DATA_WIDTH    (DW),
    .ADDRESS_WIDTH (AW),
    .FIFO_DEPTH    (DEPTH)
  ) dut (
    .clk_xb      (clk_xb),
    .rst_xb      (rst_xb),
    .alu_xb_vld  (vld[0]),
    .mul_xb_vld  (vld[1]),
    .shf_xb_vld  (vld[2]),
    .xb_alu_rdy  (xb_alu_rdy),
    .xb_mul_rdy  (xb_mul_rdy),
    .xb_shf_rdy  (xb_shf_rdy),
    .alu_xb_wadd (wa[0]),
    .mul_xb_wadd (wa[1]),
    .shf_xb_wadd (wa[2]),
    .alu_xb_dt   (din[0]),
    .mul_xb_dt   (din[1]),
    .shf_xb_dt   (din[2]),
    .xb_rf_w_En  (xb_rf_w_En),
    .xb_rf_wadd  (xb_rf_wadd),
    .xb_rf_dt    (xb_rf_dt),
    .xb_ps_busy  (xb_ps_busy)
  );

  // ---------------- scoreboard / model state ----------------
  int tests = 0;
  int fails = 0;

  xb_entry_t   mq [3][$];     // expected FIFO contents per source
  logic        m_wen;
  logic [AW-1:0] m_wadd;
  logic [DW-1:0] m_dt;
  logic [15:0] m_busy;
  int          m_ptr;
  bit          acc [3];
  logic [11:0] seq [3];

  logic [DW-1:0] exp_q [$];   // MUL data in accept order
  logic [DW-1:0] mul_seen [$];
  int            out_src [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] model_rdy();
    logic [2:0] r;
    for (int s = 0; s < 3; s++) r[s] = (mq[s].size() < DEPTH);
    return r;
  endfunction

  // One clock: advance the reference model with the inputs presented now,
  // take the edge, then compare outputs 1 time unit later.
  task automatic tick(input bit chk_model);
    int g;
    int s;
    xb_entry_t e;
    logic [15:0] nb;
    for (int i = 0; i < 3; i++) acc[i] = 1'b0;
    if (rst_xb) begin
      for (int i = 0; i < 3; i++) mq[i].delete();
      m_wen = 1'b0; m_wadd = '0; m_dt = '0; m_busy = '0; m_ptr = 0;
    end else begin
      for (int i = 0; i < 3; i++) acc[i] = vld[i] && (mq[i].size() < DEPTH);
      g = -1;
      for (int k = 0; k < 3; k++) begin
        s = (m_ptr + k) % 3;
        if (g < 0 && mq[s].size() != 0) g = s;
      end
      nb = m_busy;
      if (m_wen) nb[m_wadd] = 1'b0;
      for (int i = 0; i < 3; i++) if (acc[i]) nb[wa[i]] = 1'b1;
      m_busy = nb;
      if (g >= 0) begin
        e = mq[g].pop_front();
        m_wen = 1'b1; m_wadd = e.wadd; m_dt = e.dt;
        m_ptr = (g + 1) % 3;
      end else begin
        m_wen = 1'b0;
      end
      for (int i = 0; i < 3; i++) if (acc[i]) mq[i].push_back('{wadd: wa[i], dt: din[i]});
      if (acc[1]) exp_q.push_back(din[1]);
    end
    @(posedge clk_xb);
    #1;
    if (xb_rf_w_En) begin
      out_src.push_back(int'(xb_rf_dt[15:12]));
      if (xb_rf_dt[15:12] == 4'd2) mul_seen.push_back(xb_rf_dt);
    end
    if (chk_model) begin
      check("model_rdy", {29'd0, xb_shf_rdy, xb_mul_rdy, xb_alu_rdy}, {29'd0, model_rdy()});
      check("model_wen", {31'd0, xb_rf_w_En}, {31'd0, m_wen});
      check("model_wadd", {28'd0, xb_rf_wadd}, {28'd0, m_wadd});
      check("model_dt", {16'd0, xb_rf_dt}, {16'd0, m_dt});
      check("model_busy", {16'd0, xb_ps_busy}, {16'd0, m_busy});
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input int prob);
    for (int s = 0; s < 3; s++) begin
      if (!vld[s] && int'($urandom_range(99)) < prob) begin
        vld[s] = 1'b1;
        wa[s]  = AW'($urandom_range(15));
        din[s] = {4'(s + 1), seq[s]};
        seq[s] = seq[s] + 12'd1;
      end
    end
  endtask

  task automatic retire_accepted();
    for (int s = 0; s < 3; s++) if (acc[s]) vld[s] = 1'b0;
  endtask

  task automatic do_reset();
    rst_xb = 1'b1;
    vld = '0;
    tick(1'b0);
    tick(1'b0);
    rst_xb = 1'b0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [2:0]  v;
    logic [3:0]  a0, a1, a2;
    logic [15:0] d0, d1, d2;
    logic        e_wen;
    logic [3:0]  e_wadd;
    logic [15:0] e_dt;
    logic [15:0] e_busy;
    logic [2:0]  e_rdy;
  } vec_t;

  vec_t vt [16];

  int fair_cnt [3];
  int win_viol;
  int low_seen;
  int stray;

  initial begin
    // single write r3, SHF r7 to park the pointer at ALU, three-way
    // contention, then r5 set/clear collision
    vt[0]  = '{3'b001, 4'd3, 4'd0, 4'd0, 16'hBEEF, 16'h0, 16'h0, 1'b0, 4'd0, 16'h0000, 16'h0008, 3'b111};
    vt[1]  = '{3'b000, 4'd0, 4'd0, 4'd0, 16'h0, 16'h0, 16'h0, 1'b1, 4'd3, 16'hBEEF, 16'h0008, 3'b111};
    vt[2]  = '{3'b000, 4'd0, 4'd0, 4'd0, 16'h0, 16'h0, 16'h0, 1'b0, 4'd3, 16'hBEEF, 16'h0000, 3'b111};
    vt[3]  = '{3'b000, 4'd0, 4'd0, 4'd0, 16'h0, 16'h0, 16'h0, 1'b0, 4'd3, 16'hBEEF, 16'h0000, 3'b111};
    vt[4]  = '{3'b100, 4'd0, 4'd0, 4'd7, 16'h0, 16'h0, 16'h7777, 1'b0, 4'd3, 16'hBEEF, 16'h0080, 3'b111};
    vt[5]  = '{3'b000, 4'd0, 4'd0, 4'd0, 16'h0, 16'h0, 16'h0, 1'b1, 4'd7, 16'h7777, 16'h0080, 3'b111};
    vt[6]  = '{3'b111, 4'd1, 4'd2, 4'd3, 16'h1111, 16'h2222, 16'h3333, 1'b0, 4'd7, 16'h7777, 16'h000E, 3'b111};
    vt[7]  = '{3'b000, 4'd0, 4'd0, 4'd0, 16'h0, 16'h0, 16'h0, 1'b1, 4'd1, 16'h1111, 16'h000E, 3'b111};
    vt[8]  = '{3'b000, 4'd0, 4'd0, 4'd0, 16'h0, 16'h0, 16'h0, 1'b1, 4'd2, 16'h2222, 16'h000C, 3'b111};
    vt[9]  = '{3'b000, 4'd0, 4'd0, 4'd0, 16'h0, 16'h0, 16'h0, 1'b1, 4'd3, 16'h3333, 16'h0008, 3'b111};
    vt[10] = '{3'b000, 4'd0, 4'd0, 4'd0, 16'h0, 16'h0, 16'h0, 1'b0, 4'd3, 16'h3333, 16'h0000, 3'b111};
    vt[11] = '{3'b001, 4'd5, 4'd0, 4'd0, 16'h0505, 16'h0, 16'h0, 1'b0, 4'd3, 16'h3333, 16'h0020, 3'b111};
    vt[12] = '{3'b000, 4'd0, 4'd0, 4'd0, 16'h0, 16'h0, 16'h0, 1'b1, 4'd5, 16'h0505, 16'h0020, 3'b111};
    vt[13] = '{3'b001, 4'd5, 4'd0, 4'd0, 16'h5A5A, 16'h0, 16'h0, 1'b0, 4'd5, 16'h0505, 16'h0020, 3'b111};
    vt[14] = '{3'b000, 4'd0, 4'd0, 4'd0, 16'h0, 16'h0, 16'h0, 1'b1, 4'd5, 16'h5A5A, 16'h0020, 3'b111};
    vt[15] = '{3'b000, 4'd0, 4'd0, 4'd0, 16'h0, 16'h0, 16'h0, 1'b0, 4'd5, 16'h5A5A, 16'h0000, 3'b111};

    vld = '0;
    for (int s = 0; s < 3; s++) begin
      wa[s] = '0; din[s] = '0; seq[s] = '0;
    end

    // reset state
    do_reset();
    check("rst_rdy", {29'd0, xb_shf_rdy, xb_mul_rdy, xb_alu_rdy}, 32'h7);
    check("rst_wen", {31'd0, xb_rf_w_En}, 32'h0);
    check("rst_wadd", {28'd0, xb_rf_wadd}, 32'h0);
    check("rst_dt", {16'd0, xb_rf_dt}, 32'h0);
    check("rst_busy", {16'd0, xb_ps_busy}, 32'h0);

    // directed table
    for (int i = 0; i < 16; i++) begin
      vld = vt[i].v;
      wa[0] = vt[i].a0; wa[1] = vt[i].a1; wa[2] = vt[i].a2;
      din[0] = vt[i].d0; din[1] = vt[i].d1; din[2] = vt[i].d2;
      tick(1'b1);
      check($sformatf("vec%0d_wen", i), {31'd0, xb_rf_w_En}, {31'd0, vt[i].e_wen});
      check($sformatf("vec%0d_wadd", i), {28'd0, xb_rf_wadd}, {28'd0, vt[i].e_wadd});
      check($sformatf("vec%0d_dt", i), {16'd0, xb_rf_dt}, {16'd0, vt[i].e_dt});
      check($sformatf("vec%0d_busy", i), {16'd0, xb_ps_busy}, {16'd0, vt[i].e_busy});
      check($sformatf("vec%0d_rdy", i), {29'd0, xb_shf_rdy, xb_mul_rdy, xb_alu_rdy}, {29'd0, vt[i].e_rdy});
    end
    vld = '0;

    // back-pressure: lone MUL stream never fills, then ALU+SHF compete
    do_reset();
    exp_q.delete(); mul_seen.delete();
    for (int i = 0; i < 3; i++) begin
      vld[1] = 1'b1; wa[1] = AW'(i + 8); din[1] = {4'd2, seq[1]}; seq[1] = seq[1] + 12'd1;
      tick(1'b1);
      check("bp_mul_rdy_idle", {31'd0, xb_mul_rdy}, 32'h1);
      retire_accepted();
    end
    low_seen = 0;
    for (int i = 0; i < 12; i++) begin
      drive(100);
      tick(1'b1);
      if (!xb_mul_rdy) low_seen++;
      retire_accepted();
    end
    check("bp_mul_rdy_dropped", {31'd0, (low_seen > 0)}, 32'h1);
    vld = '0;
    for (int i = 0; i < 10; i++) tick(1'b1);
    check("bp_mul_count", mul_seen.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < mul_seen.size(); i++)
      check("bp_mul_order", {16'd0, mul_seen[i]}, {16'd0, exp_q[i]});

    // fairness: all sources valid every cycle
    do_reset();
    out_src.delete();
    for (int i = 0; i < 31; i++) begin
      drive(100);
      tick(1'b1);
      retire_accepted();
    end
    vld = '0;
    check("fair_total", out_src.size(), 30);
    for (int s = 0; s < 3; s++) fair_cnt[s] = 0;
    win_viol = 0;
    for (int i = 0; i < out_src.size(); i++) begin
      if (out_src[i] >= 1 && out_src[i] <= 3) fair_cnt[out_src[i] - 1]++;
      if (i >= 1 && out_src[i] == out_src[i-1]) win_viol++;
      if (i >= 2 && out_src[i] == out_src[i-2]) win_viol++;
    end
    check("fair_alu", fair_cnt[0], 10);
    check("fair_mul", fair_cnt[1], 10);
    check("fair_shf", fair_cnt[2], 10);
    check("fair_window", win_viol, 0);
    for (int i = 0; i < 6; i++) tick(1'b1);

    // reset with four entries buffered
    do_reset();
    vld = 3'b111;
    for (int s = 0; s < 3; s++) begin
      wa[s] = AW'(s + 1); din[s] = {4'(s + 1), 12'hF00};
    end
    tick(1'b1);
    vld = 3'b011;
    wa[0] = 4'd9; din[0] = 16'h1F01; wa[1] = 4'd10; din[1] = 16'h2F01;
    tick(1'b1);
    rst_xb = 1'b1;
    vld = '0;
    tick(1'b1);
    rst_xb = 1'b0;
    check("midrst_wen", {31'd0, xb_rf_w_En}, 32'h0);
    check("midrst_busy", {16'd0, xb_ps_busy}, 32'h0);
    check("midrst_rdy", {29'd0, xb_shf_rdy, xb_mul_rdy, xb_alu_rdy}, 32'h7);
    stray = 0;
    for (int i = 0; i < 8; i++) begin
      tick(1'b1);
      if (xb_rf_w_En) stray++;
    end
    check("midrst_no_writes", stray, 0);

    // randomized traffic against the model, with one reset in the middle
    do_reset();
    for (int i = 0; i < 400; i++) begin
      drive(55);
      rst_xb = (i == 200);
      tick(1'b1);
      retire_accepted();
    end
    rst_xb = 1'b0;
    vld = '0;
    for (int i = 0; i < 8; i++) tick(1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
